dtim_param: RTL and testbench

Parametrised data tightly-integrated memory for the BA20x core: a single-port, byte-maskable scratchpad on the core's load/store path. It adds several things the fixed 1024×32 version lacks: configurable width and depth, a base-address window with out-of-range error reporting, a valid/ready request handshake, a selectable read latency, and an optional clear-on-reset sweep. It sits between the LSU and the memory map decoder.

---
 rtl/dtim_pkg.sv | 29 ++
 rtl/dtim_sram.sv | 34 +++
 rtl/dtim_param.sv | 158 +++++++++++++++
 tb/tb_dtim_param.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtim_pkg.sv
// Shared types, legality constants and helpers for the parametrised data TIM.
package dtim_pkg;

   typedef enum logic [0:0] {DTIM_CLEAR, DTIM_IDLE} dtim_state_e;

   localparam int unsigned DtimMinDepth   = 16;
   localparam int unsigned DtimMinLatency = 1;
   localparam int unsigned DtimMaxLatency = 2;

   // Number of byte-offset bits dropped from the byte address to form a word index.
   function automatic int unsigned dtim_off_w(input int unsigned data_width);
      return $clog2(data_width / 8);
   endfunction

   function automatic bit dtim_params_ok(input int unsigned data_width,
                                         input int unsigned depth,
                                         input int unsigned latency,
                                         input logic [31:0] base_addr);
      longint unsigned win;
      longint unsigned base;
      win  = longint'(depth) * longint'(data_width / 8);
      base = {32'h0, base_addr};
      return ((data_width == 32) || (data_width == 64)) &&
             (depth >= DtimMinDepth) && ((depth & (depth - 1)) == 0) &&
             (latency >= DtimMinLatency) && (latency <= DtimMaxLatency) &&
             ((base % win) == 0);
   endfunction

endpackage

// File: rtl/dtim_sram.sv
// Single-port synchronous RAM, per-byte write enable, write-first read data.
module dtim_sram #(
   parameter  int unsigned DATA_WIDTH = 32,
   parameter  int unsigned DEPTH      = 1024,
   localparam int unsigned AddrW      = $clog2(DEPTH),
   localparam int unsigned NumBytes   = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  en_i,
   input  logic [NumBytes-1:0]   we_i,
   input  logic [AddrW-1:0]      addr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         for (int b = 0; b < NumBytes; b++) begin
            if (we_i[b]) begin
               mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
               rdata_q[8*b +: 8]       <= wdata_i[8*b +: 8];
            end else begin
               rdata_q[8*b +: 8]       <= mem_q[addr_i][8*b +: 8];
            end
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dtim_param.sv
// Parametrised data TIM: address window check, valid/ready request, 1- or 2-cycle response.
// Define DTIM_CLEAR_ON_RESET_EN to zero the whole array with a sweep after every reset.
module dtim_param
   import dtim_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned DEPTH        = 1024,
   parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    dtim_i_valid,
   output logic                    dtim_o_ready,
   input  logic [31:0]             dtim_i_addr,
   input  logic [DATA_WIDTH/8-1:0] dtim_i_wmask,
   input  logic [DATA_WIDTH-1:0]   dtim_i_wdata,
   output logic                    dtim_o_rvalid,
   output logic [DATA_WIDTH-1:0]   dtim_o_rdata,
   output logic                    dtim_o_err
);

   localparam int unsigned NumBytes = DATA_WIDTH / 8;
   localparam int unsigned OffW     = dtim_off_w(DATA_WIDTH);
   localparam int unsigned IdxW     = $clog2(DEPTH);
   localparam logic [32:0] WinBytes = 33'(longint'(DEPTH) * longint'(NumBytes));

   if (!dtim_params_ok(DATA_WIDTH, DEPTH, READ_LATENCY, BASE_ADDR)) begin : gen_bad_params
      $error("dtim_param: unsupported DATA_WIDTH/DEPTH/BASE_ADDR/READ_LATENCY");
   end

   logic [31:0]           offset;
   logic                  in_range;
   logic                  accept;
   logic                  hit;
   logic                  sweep;
   logic [IdxW-1:0]       req_idx;
   logic [IdxW-1:0]       clear_idx;
   logic                  ram_en;
   logic [NumBytes-1:0]   ram_we;
   logic [IdxW-1:0]       ram_addr;
   logic [DATA_WIDTH-1:0] ram_wdata;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic [DATA_WIDTH-1:0] rdata1;
   logic                  rvalid1_q;
   logic                  err1_q;
   logic                  zero1_q;
   logic                  unused_offset;

   // Below-base addresses wrap to huge offsets, so one compare covers both ends.
   assign offset        = dtim_i_addr - BASE_ADDR;
   assign in_range      = {1'b0, offset} < WinBytes;
   assign req_idx       = offset[OffW +: IdxW];
   assign unused_offset = ^offset;
   assign accept        = dtim_i_valid & dtim_o_ready;
   assign hit           = accept & in_range;

`ifdef DTIM_CLEAR_ON_RESET_EN
   dtim_state_e     state_q;
   logic [IdxW-1:0] cnt_q;
   logic            ready_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DTIM_CLEAR;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else if (state_q == DTIM_CLEAR) begin
         cnt_q <= cnt_q + IdxW'(1);
         if (cnt_q == IdxW'(DEPTH - 1)) begin
            state_q <= DTIM_IDLE;
            ready_q <= 1'b1;
         end
      end
   end

   assign sweep        = (state_q == DTIM_CLEAR) & ~rst;
   assign clear_idx    = cnt_q;
   assign dtim_o_ready = ready_q & ~rst;
`else
   assign sweep        = 1'b0;
   assign clear_idx    = '0;
   assign dtim_o_ready = ~rst;
`endif

   // Sweep and requests never overlap: ready is low for the whole sweep.
   always_comb begin
      ram_en    = sweep | hit;
      ram_we    = '0;
      ram_addr  = req_idx;
      ram_wdata = dtim_i_wdata;
      if (sweep) begin
         ram_we    = '1;
         ram_addr  = clear_idx;
         ram_wdata = '0;
      end else if (hit) begin
         ram_we    = dtim_i_wmask;
      end
   end

   dtim_sram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_sram (
      .clk_i   (clk),
      .en_i    (ram_en),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   // zero1_q masks the RAM output after reset and for out-of-range responses.
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid1_q <= 1'b0;
         err1_q    <= 1'b0;
         zero1_q   <= 1'b1;
      end else begin
         rvalid1_q <= accept;
         if (accept) begin
            err1_q  <= ~in_range;
            zero1_q <= ~in_range;
         end
      end
   end

   assign rdata1 = zero1_q ? '0 : ram_rdata;

   if (READ_LATENCY == 2) begin : gen_lat2
      logic                  rvalid2_q;
      logic                  err2_q;
      logic [DATA_WIDTH-1:0] rdata2_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            rvalid2_q <= 1'b0;
            err2_q    <= 1'b0;
            rdata2_q  <= '0;
         end else begin
            rvalid2_q <= rvalid1_q;
            if (rvalid1_q) begin
               err2_q   <= err1_q;
               rdata2_q <= rdata1;
            end
         end
      end

      assign dtim_o_rvalid = rvalid2_q;
      assign dtim_o_err    = err2_q;
      assign dtim_o_rdata  = rdata2_q;
   end else begin : gen_lat1
      assign dtim_o_rvalid = rvalid1_q;
      assign dtim_o_err    = err1_q;
      assign dtim_o_rdata  = rdata1;
   end

endmodule

// File: tb/tb_dtim_param.sv
// Scoreboard bench for dtim_param: a 32-bit/latency-1 and a 64-bit/latency-2 instance.
module tb_dtim_param;

   localparam logic [31:0] BaseA  = 32'h8000_0000;
   localparam logic [31:0] BaseB  = 32'h4000_0000;
   localparam int          DepthA = 1024;
   localparam int          DepthB = 16;

   typedef struct {
      logic [63:0] data;
      logic        err;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid [2];
   logic [31:0] addr  [2];
   logic [7:0]  wmask [2];
   logic [63:0] wdata [2];
   logic        ready_a, ready_b, rvalid_a, rvalid_b, err_a, err_b;
   logic [31:0] rdata_a;
   logic [63:0] rdata_b;

   exp_t        q0[$];
   exp_t        q1[$];
   logic [63:0] mem [int];
   int          clear_left [2];
   logic [63:0] last_data [2];
   logic        last_err [2];
   int          cyc = 0;
   bit          started = 0;
   int          total = 0;
   int          passed = 0;

   always #5 clk = ~clk;

   dtim_param #(
      .DATA_WIDTH   (32),
      .DEPTH        (DepthA),
      .BASE_ADDR    (BaseA),
      .READ_LATENCY (1)
   ) u_dut_a (
      .clk           (clk),
      .rst           (rst),
      .dtim_i_valid  (valid[0]),
      .dtim_o_ready  (ready_a),
      .dtim_i_addr   (addr[0]),
      .dtim_i_wmask  (wmask[0][3:0]),
      .dtim_i_wdata  (wdata[0][31:0]),
      .dtim_o_rvalid (rvalid_a),
      .dtim_o_rdata  (rdata_a),
      .dtim_o_err    (err_a)
   );

   dtim_param #(
      .DATA_WIDTH   (64),
      .DEPTH        (DepthB),
      .BASE_ADDR    (BaseB),
      .READ_LATENCY (2)
   ) u_dut_b (
      .clk           (clk),
      .rst           (rst),
      .dtim_i_valid  (valid[1]),
      .dtim_o_ready  (ready_b),
      .dtim_i_addr   (addr[1]),
      .dtim_i_wmask  (wmask[1]),
      .dtim_i_wdata  (wdata[1]),
      .dtim_o_rvalid (rvalid_b),
      .dtim_o_rdata  (rdata_b),
      .dtim_o_err    (err_b)
   );

   function automatic int nbytes(input int d);
      return (d == 0) ? 4 : 8;
   endfunction

   function automatic int depth_of(input int d);
      return (d == 0) ? DepthA : DepthB;
   endfunction

   function automatic logic [31:0] base_of(input int d);
      return (d == 0) ? BaseA : BaseB;
   endfunction

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 2;
   endfunction

   function automatic bit ready_exp(input int d);
      return !rst && (clear_left[d] == 0);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference: window test, byte-lane merge, write-first response, zero data on error.
   task automatic model_op(input int d, input logic [31:0] a, input logic [7:0] m,
                           input logic [63:0] wd, output exp_t e);
      longint unsigned lo, hi, av;
      int              key;
      logic [63:0]     w;
      lo     = {32'h0, base_of(d)};
      hi     = lo + longint'(depth_of(d) * nbytes(d));
      av     = {32'h0, a};
      e.data = '0;
      e.err  = !((av >= lo) && (av < hi));
      e.due  = 0;
      if (!e.err) begin
         key = d * 65536 + int'((av - lo) / longint'(nbytes(d)));
         w   = mem.exists(key) ? mem[key] : 64'h0;
         for (int i = 0; i < nbytes(d); i++) if (m[i]) w[8*i +: 8] = wd[8*i +: 8];
         mem[key] = w;
         e.data   = w;
      end
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   function automatic exp_t qfront(input int d);
      return (d == 0) ? q0[0] : q1[0];
   endfunction

   task automatic qpop(input int d, output exp_t e);
      if (d == 0) e = q0.pop_front();
      else e = q1.pop_front();
   endtask

   // Stimulus side: record each accepted request in the scoreboard.
   always @(posedge clk) begin
      exp_t e;
      cyc++;
      if (rst) begin
         started = 1;
         q0.delete();
         q1.delete();
         for (int d = 0; d < 2; d++) begin
            last_data[d] = '0;
            last_err[d]  = 1'b0;
`ifdef DTIM_CLEAR_ON_RESET_EN
            clear_left[d] = depth_of(d);
`endif
         end
`ifdef DTIM_CLEAR_ON_RESET_EN
         mem.delete();
`endif
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (valid[d] && ready_exp(d)) begin
               model_op(d, addr[d], wmask[d], wdata[d], e);
               e.due = cyc + lat_of(d) - 1;
               if (d == 0) q0.push_back(e);
               else q1.push_back(e);
            end
            if (clear_left[d] > 0) clear_left[d]--;
         end
      end
   end

   // Monitor side: compare every presented response against the queue head.
   always @(negedge clk) begin
      exp_t        e;
      logic        rv, rdy, er;
      logic [63:0] rd;
      if (started) begin
         for (int d = 0; d < 2; d++) begin
            rv  = (d == 0) ? rvalid_a : rvalid_b;
            rdy = (d == 0) ? ready_a : ready_b;
            er  = (d == 0) ? err_a : err_b;
            rd  = (d == 0) ? {32'h0, rdata_a} : rdata_b;
            chk($sformatf("ready[%0d]", d), {63'h0, rdy}, {63'h0, ready_exp(d)});
            if (rv) begin
               if (qsize(d) == 0) begin
                  chk($sformatf("spurious_rvalid[%0d]", d), 64'd1, 64'd0);
               end else begin
                  qpop(d, e);
                  chk($sformatf("latency_cycle[%0d]", d), 64'(cyc), 64'(e.due));
                  chk($sformatf("rdata[%0d]", d), rd, e.data);
                  chk($sformatf("err[%0d]", d), {63'h0, er}, {63'h0, e.err});
                  last_data[d] = e.data;
                  last_err[d]  = e.err;
               end
            end else begin
               chk($sformatf("hold_rdata[%0d]", d), rd, last_data[d]);
               chk($sformatf("hold_err[%0d]", d), {63'h0, er}, {63'h0, last_err[d]});
               if (qsize(d) > 0 && qfront(d).due <= cyc) begin
                  qpop(d, e);
                  chk($sformatf("missing_rvalid[%0d]", d), 64'd0, 64'd1);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      for (int d = 0; d < 2; d++) begin
         valid[d] = 1'b0;
         addr[d]  = '0;
         wmask[d] = '0;
         wdata[d] = '0;
      end
   endtask

   task automatic set_req(input int d, input logic [31:0] a, input logic [7:0] m,
                          input logic [63:0] wd);
      valid[d] = 1'b1;
      addr[d]  = a;
      wmask[d] = m;
      wdata[d] = wd;
   endtask

   task automatic one(input int d, input logic [31:0] a, input logic [7:0] m,
                      input logic [63:0] wd);
      set_req(d, a, m, wd);
      tick();
      idle_all();
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!(ready_exp(0) && ready_exp(1)) && n < 3000) begin
         tick();
         n++;
      end
      if (n >= 3000) chk("ready_timeout", 64'd0, 64'd1);
   endtask

   task automatic rand_req(input int d);
      int          w, sel;
      logic [31:0] a;
      logic [7:0]  m;
      w   = (d == 0) ? $urandom_range(31) : $urandom_range(15);
      sel = $urandom_range(9);
      a   = base_of(d) + 32'(w * nbytes(d)) + 32'($urandom_range(nbytes(d) - 1));
      if (sel == 0) a = base_of(d) + 32'(depth_of(d) * nbytes(d)) + 32'(w * nbytes(d));
      if (sel == 1) a = base_of(d) - 32'((w + 1) * nbytes(d));
      m = (d == 0) ? 8'($urandom_range(15)) : 8'($urandom_range(255));
      if ($urandom_range(1) == 0) m = '0;
      set_req(d, a, m, {$urandom, $urandom});
   endtask

   initial begin
      clear_left[0] = 0;
      clear_left[1] = 0;
      idle_all();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      wait_ready();

      // Give every word the traffic touches a known value.
      for (int i = 0; i < 32; i++) begin
         set_req(0, BaseA + 32'(i * 4), 8'h0F, {32'h0, $urandom});
         if (i < 16) set_req(1, BaseB + 32'(i * 8), 8'hFF, {$urandom, $urandom});
         tick();
         idle_all();
      end

      one(0, 32'h8000_0010, 8'h0F, 64'hDEAD_BEEF);
      one(0, 32'h8000_0010, 8'h00, 64'h0);
      one(0, 32'h8000_0010, 8'h01, 64'h11);
      one(0, 32'h8000_0010, 8'h00, 64'h0);
      one(0, 32'h8000_1000, 8'h00, 64'h0);
      one(0, 32'h7FFF_FFFC, 8'h00, 64'h0);
      one(0, 32'h8000_1000, 8'h0F, 64'h1234_5678);
      one(0, 32'h8000_0010, 8'h00, 64'h0);
      one(0, 32'h8000_0000, 8'h00, 64'h0);
      one(1, BaseB + 32'd128, 8'h00, 64'h0);
      one(1, BaseB - 32'd8, 8'h00, 64'h0);

      for (int i = 0; i < 8; i++) begin
         set_req(1, BaseB + 32'(i * 8), 8'h00, 64'h0);
         tick();
      end
      idle_all();
      repeat (3) tick();

      for (int n = 0; n < 400; n++) begin
         for (int d = 0; d < 2; d++) if ($urandom_range(3) != 0) rand_req(d);
         tick();
         idle_all();
      end

      // Reset with a latency-2 read in flight, and writes offered while reset is high.
      set_req(1, BaseB, 8'h00, 64'h0);
      set_req(0, BaseA + 32'd8, 8'h00, 64'h0);
      tick();
      idle_all();
      rst = 1'b1;
      set_req(0, BaseA + 32'd8, 8'h0F, 64'hCAFE_F00D);
      set_req(1, BaseB + 32'd8, 8'hFF, 64'h0123_4567_89AB_CDEF);
      tick();
      tick();
      idle_all();
      rst = 1'b0;
      wait_ready();
      one(0, BaseA + 32'd8, 8'h00, 64'h0);
      one(1, BaseB + 32'd8, 8'h00, 64'h0);

      // Second reset seven cycles into the first sweep.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_ready();

      for (int i = 0; i < 32; i++) begin
         set_req(0, BaseA + 32'(i * 4), 8'h00, 64'h0);
         if (i < 16) set_req(1, BaseB + 32'(i * 8), 8'h00, 64'h0);
         tick();
         idle_all();
      end

      repeat (6) tick();
      chk("drain_queue[0]", 64'(q0.size()), 64'd0);
      chk("drain_queue[1]", 64'(q1.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
